// File: rtl/axi_lite2mem_pkg.sv
// Shared types and constants for the AXI-Lite to peripheral-bus bridge.
package axi_lite2mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AW_ACK,
    W_WAIT,
    W_DEV,
    AR_ACK,
    R_DEV,
    R_RESP
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int unsigned WORD_BYTES   = 4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite subset used by the core-side bridge: AW, W (with wlast), AR, R (with rlast).
interface AXI_LITE;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        rlast;

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, wlast, araddr, arvalid, rready,
    output awready, wready, arready, rdata, rvalid, rlast
  );

  modport master (
    output awaddr, awvalid, wdata, wvalid, wlast, araddr, arvalid, rready,
    input  awready, wready, arready, rdata, rvalid, rlast
  );
endinterface

// File: rtl/axi_lite2mem_dev_timeout.sv
// Peripheral response watchdog: counts stalled request cycles and flags the last allowed one.
module dev_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic start_i,
  input  logic busy_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
    end else if (busy_i && !ready_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Fires in the TIMEOUT-th stalled cycle so the FSM can drop the request on that edge.
  assign expired_o = busy_i && !ready_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/axi_lite2mem.sv
// AXI-Lite responder driving a valid/ready peripheral bus; supports single reads and wlast-terminated write bursts.
module axi_lite2mem
  import axi_lite2mem_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 255,
  parameter bit          LAST_IS_DATA = 1'b1,
  parameter logic [31:0] ERR_DATA     = ERR_DATA_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  AXI_LITE.slave        axi_slave,
  output logic          dev_valid,
  input  logic          dev_ready,
  output logic [31:0]   dev_addr,
  output logic [31:0]   dev_wdata,
  output logic [3:0]    dev_wstrb,
  input  logic [31:0]   dev_rdata,
  output logic          timeout_o
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic [31:0] dev_addr_q;
  logic [31:0] dev_wdata_q;
  logic [3:0]  dev_wstrb_q;
  logic        awready_q, wready_q, arready_q;
  logic        rvalid_q, rlast_q;
  logic        dev_valid_q, timeout_q, wlast_q;

  logic w_hs, w_term, tmo_start, tmo_expired, dev_done;

  assign w_hs      = (state_q == W_WAIT) && axi_slave.wvalid && wready_q;
  assign w_term    = axi_slave.wlast && !LAST_IS_DATA;
  assign tmo_start = (w_hs && !w_term) || (state_q == AR_ACK);
  assign dev_done  = dev_ready || tmo_expired;

  dev_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (tmo_start),
    .busy_i    (dev_valid_q),
    .ready_i   (dev_ready),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rdata_q     <= '0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      dev_wstrb_q <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      dev_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      wlast_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (axi_slave.awvalid) begin
            addr_q    <= word_align(axi_slave.awaddr);
            awready_q <= 1'b1;
            state_q   <= AW_ACK;
          end else if (axi_slave.arvalid) begin
            addr_q    <= word_align(axi_slave.araddr);
            arready_q <= 1'b1;
            state_q   <= AR_ACK;
          end
        end
        AW_ACK: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          state_q   <= W_WAIT;
        end
        W_WAIT: begin
          if (w_hs) begin
            wready_q <= 1'b0;
            wlast_q  <= axi_slave.wlast;
            if (w_term) begin
              state_q <= IDLE;
            end else begin
              dev_valid_q <= 1'b1;
              dev_addr_q  <= addr_q;
              dev_wdata_q <= axi_slave.wdata;
              dev_wstrb_q <= 4'hF;
              state_q     <= W_DEV;
            end
          end
        end
        W_DEV: begin
          // A timed-out write is simply dropped; the burst continues as if acknowledged.
          if (dev_done) begin
            dev_valid_q <= 1'b0;
            dev_wstrb_q <= 4'h0;
            timeout_q   <= tmo_expired;
            if (wlast_q) begin
              state_q <= IDLE;
            end else begin
              addr_q   <= addr_q + 32'(WORD_BYTES);
              wready_q <= 1'b1;
              state_q  <= W_WAIT;
            end
          end
        end
        AR_ACK: begin
          arready_q   <= 1'b0;
          dev_valid_q <= 1'b1;
          dev_addr_q  <= addr_q;
          dev_wstrb_q <= 4'h0;
          state_q     <= R_DEV;
        end
        R_DEV: begin
          if (dev_done) begin
            dev_valid_q <= 1'b0;
            rdata_q     <= dev_ready ? dev_rdata : ERR_DATA;
            timeout_q   <= tmo_expired;
            rvalid_q    <= 1'b1;
            rlast_q     <= 1'b1;
            state_q     <= R_RESP;
          end
        end
        R_RESP: begin
          if (axi_slave.rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign axi_slave.awready = awready_q;
  assign axi_slave.wready  = wready_q;
  assign axi_slave.arready = arready_q;
  assign axi_slave.rdata   = rdata_q;
  assign axi_slave.rvalid  = rvalid_q;
  assign axi_slave.rlast   = rlast_q;
  assign dev_valid         = dev_valid_q;
  assign dev_addr          = dev_addr_q;
  assign dev_wdata         = dev_wdata_q;
  assign dev_wstrb         = dev_wstrb_q;
  assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_axi_lite2mem.sv
// Scoreboard bench for axi_lite2mem: one instance with data-carrying wlast, one with terminator-only wlast.
module tb_axi_lite2mem;
  import axi_lite2mem_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // sel picks which instance the shared stimulus/observation signals talk to
  logic        sel = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, dev_rdata = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        dev_ready = 1'b0;

  AXI_LITE ax0();
  AXI_LITE ax1();

  logic        dv0, dv1, to0, to1;
  logic [31:0] da0, da1, dw0, dw1;
  logic [3:0]  ds0, ds1;

  assign ax0.awaddr  = awaddr;
  assign ax0.awvalid = awvalid & ~sel;
  assign ax0.wdata   = wdata;
  assign ax0.wvalid  = wvalid & ~sel;
  assign ax0.wlast   = wlast;
  assign ax0.araddr  = araddr;
  assign ax0.arvalid = arvalid & ~sel;
  assign ax0.rready  = rready & ~sel;
  assign ax1.awaddr  = awaddr;
  assign ax1.awvalid = awvalid & sel;
  assign ax1.wdata   = wdata;
  assign ax1.wvalid  = wvalid & sel;
  assign ax1.wlast   = wlast;
  assign ax1.araddr  = araddr;
  assign ax1.arvalid = arvalid & sel;
  assign ax1.rready  = rready & sel;

  axi_lite2mem #(.TIMEOUT(8), .LAST_IS_DATA(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .axi_slave(ax0.slave),
    .dev_valid(dv0), .dev_ready(dev_ready & ~sel), .dev_addr(da0), .dev_wdata(dw0),
    .dev_wstrb(ds0), .dev_rdata(dev_rdata), .timeout_o(to0)
  );

  axi_lite2mem #(.TIMEOUT(8), .LAST_IS_DATA(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .axi_slave(ax1.slave),
    .dev_valid(dv1), .dev_ready(dev_ready & sel), .dev_addr(da1), .dev_wdata(dw1),
    .dev_wstrb(ds1), .dev_rdata(dev_rdata), .timeout_o(to1)
  );

  logic        awready, wready, arready, rvalid, rlast, dev_valid, timeout_o;
  logic [31:0] rdata, dev_addr, dev_wdata;
  logic [3:0]  dev_wstrb;
  assign awready   = sel ? ax1.awready : ax0.awready;
  assign wready    = sel ? ax1.wready  : ax0.wready;
  assign arready   = sel ? ax1.arready : ax0.arready;
  assign rvalid    = sel ? ax1.rvalid  : ax0.rvalid;
  assign rlast     = sel ? ax1.rlast   : ax0.rlast;
  assign rdata     = sel ? ax1.rdata   : ax0.rdata;
  assign dev_valid = sel ? dv1 : dv0;
  assign dev_addr  = sel ? da1 : da0;
  assign dev_wdata = sel ? dw1 : dw0;
  assign dev_wstrb = sel ? ds1 : ds0;
  assign timeout_o = sel ? to1 : to0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } dev_exp_t;

  dev_exp_t    dev_q[$];
  logic [31:0] rd_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int dev_dly = 0;
  bit dev_dead = 1'b0;
  int run = 0;
  int last_run = 0;
  int tmo_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Peripheral model: answers after dev_dly stalled cycles and scores each access against dev_q.
  initial begin : responder
    dev_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (timeout_o) tmo_cnt++;
      if (dev_ready) dev_ready = 1'b0;
      if (dev_valid) begin
        run++;
        if (!dev_dead && run == dev_dly + 1) begin
          if (dev_q.size() == 0) begin
            check("dev_unexpected", 32'(dev_q.size()), 32'd1);
          end else begin
            e = dev_q.pop_front();
            check("dev_addr", dev_addr, e.addr);
            check("dev_wstrb", 32'(dev_wstrb), 32'(e.wstrb));
            if (e.wstrb == 4'hF) check("dev_wdata", dev_wdata, e.wdata);
            dev_rdata = e.rdata;
          end
          dev_ready = 1'b1;
        end
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end
    end
  end

  task automatic aw_send(input logic [31:0] a, output int lat);
    awaddr = a;
    awvalid = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!awready && lat < 100);
    if (!awready) check("aw_wait", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    wdata = d;
    wlast = l;
    wvalid = 1'b1;
    while (!wready && n < 100) begin tick(); n++; end
    if (!wready) check("w_wait", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] a, input int nb, input logic [31:0] d0,
                             input logic [31:0] step, input bit lid, input bit push);
    int lat;
    logic [31:0] d, ad;
    ad = {a[31:2], 2'b00};
    aw_send(a, lat);
    check("aw_latency", 32'(lat), 32'd1);
    for (int i = 0; i < nb; i++) begin
      d = d0 + step * 32'(i);
      if (push && (lid || i != nb - 1)) dev_q.push_back('{ad, d, 4'hF, 32'h0});
      w_send(d, i == nb - 1);
      ad = ad + 32'd4;
    end
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [31:0] rd, input int hold,
                          input bit chk_lat, input bit dead);
    int n;
    logic [31:0] exp;
    n = 0;
    if (!dead) dev_q.push_back('{{a[31:2], 2'b00}, 32'h0, 4'h0, rd});
    rd_q.push_back(dead ? 32'hDEAD_BEEF : rd);
    araddr = a;
    arvalid = 1'b1;
    do begin tick(); n++; end while (!arready && n < 100);
    if (!arready) check("ar_wait", 32'(arready), 32'd1);
    tick();
    n++;
    arvalid = 1'b0;
    while (!rvalid && n < 100) begin tick(); n++; end
    if (chk_lat) check("rd_latency", 32'(n), 32'd3);
    check("rvalid", 32'(rvalid), 32'd1);
    exp = rd_q.pop_front();
    check("rdata", rdata, exp);
    check("rlast", 32'(rlast), 32'd1);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, exp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_clr", 32'(rvalid), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0;
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rlast", 32'(rlast), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_dev_valid", 32'(dev_valid), 32'd0);
      check("rst_dev_addr", dev_addr, 32'd0);
      check("rst_dev_wdata", dev_wdata, 32'd0);
      check("rst_dev_wstrb", 32'(dev_wstrb), 32'd0);
      check("rst_timeout", 32'(timeout_o), 32'd0);
    end
    sel = 1'b0;
    resetn = 1'b1;
    tick();

    // single write
    dev_dly = 2;
    write_burst(32'h1000_0010, 1, 32'hCAFE_0001, 32'h0, 1'b1, 1'b1);
    repeat (6) tick();
    check("wr_idle", 32'(dut_a.state_q), 32'(IDLE));
    check("wr_drained", 32'(dev_q.size()), 32'd0);

    // terminator-only wlast burst
    sel = 1'b1;
    dev_dly = 1;
    write_burst(32'h2000_0000, 4, 32'h11, 32'h11, 1'b0, 1'b1);
    repeat (10) tick();
    check("burst_drained", 32'(dev_q.size()), 32'd0);
    check("burst_idle", 32'(dut_b.state_q), 32'(IDLE));
    sel = 1'b0;
    tick();

    // single read: minimum latency and rdata held under back-pressure
    dev_dly = 0;
    read_txn(32'h3000_0004, 32'h1234_5678, 5, 1'b1, 1'b0);
    read_txn(32'h3000_0006, 32'h0BAD_F00D, 0, 1'b1, 1'b0);

    // read timeout
    t0 = tmo_cnt;
    dev_dead = 1'b1;
    read_txn(32'h4000_0000, 32'h0, 0, 1'b0, 1'b1);
    dev_dead = 1'b0;
    check("rd_tmo_pulses", 32'(tmo_cnt - t0), 32'd1);
    check("rd_tmo_cycles", 32'(last_run), 32'd8);

    // write timeout is dropped silently and the bridge recovers
    t0 = tmo_cnt;
    dev_dead = 1'b1;
    write_burst(32'h6000_0000, 1, 32'h99, 32'h0, 1'b1, 1'b0);
    repeat (12) tick();
    dev_dead = 1'b0;
    check("wr_tmo_pulses", 32'(tmo_cnt - t0), 32'd1);

    // simultaneous AW and AR: write first
    dev_dly = 2;
    araddr = 32'h3000_0100;
    arvalid = 1'b1;
    write_burst(32'h1000_0020, 1, 32'h5555_0001, 32'h0, 1'b1, 1'b1);
    read_txn(32'h3000_0100, 32'h7777_0002, 0, 1'b0, 1'b0);

    // address wrap
    dev_dly = 1;
    write_burst(32'hFFFF_FFFC, 2, 32'hA5A5_0000, 32'h1, 1'b1, 1'b1);
    repeat (6) tick();
    check("wrap_drained", 32'(dev_q.size()), 32'd0);

    // reset during W_DEV
    dev_dly = 20;
    write_burst(32'h5000_0000, 1, 32'h77, 32'h0, 1'b1, 1'b1);
    check("pre_rst_dev_valid", 32'(dev_valid), 32'd1);
    resetn = 1'b0;
    tick();
    check("rst_mid_dev_valid", 32'(dev_valid), 32'd0);
    check("rst_mid_state", 32'(dut_a.state_q), 32'(IDLE));
    check("rst_mid_wstrb", 32'(dev_wstrb), 32'd0);
    resetn = 1'b1;
    dev_q.delete();
    dev_dly = 1;
    tick();
    read_txn(32'h3000_0008, 32'h0F0F_1234, 0, 1'b0, 1'b0);

    repeat (10) tick();
    check("end_dev_q", 32'(dev_q.size()), 32'd0);
    check("end_rd_q", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
